ram_sp_arbiter: RTL
===================

// Module: ram_sp_arbiter
// PURPOSE
//  Shares one single-port byte-masked RAM (cen/wen/bwen/addr/din, registered dout, 1-cycle read)
//  between two requesters, A and B. Round-robin arbitration; at most one RAM access per cycle.
//  Optionally fills every RAM word with INIT_VALUE after reset, before any request is accepted.
//  Sits between the RAM instance and two client blocks, e.g. a DMA and a CPU port.
// PARAMETERS
//  DATA_WIDTH  32  RAM word width; multiple of 8
//  DEPTH       16  RAM words; need not be a power of 2
//  INIT_EN     1   1: run the INIT fill after reset; 0: skip it
//  INIT_VALUE  0   word written to every address during INIT (DATA_WIDTH bits)
//  Derived: AW=$clog2(DEPTH), BW=DATA_WIDTH/8
// PORTS
//  clock      in   1   clock; all logic on posedge
//  reset      in   1   synchronous, active-high
//  init_done  out  1   1 = INIT finished; requests are accepted
//  a_req      in   1   A request; held, with a_we/a_bwen/a_addr/a_wdata stable, until a_gnt
//  a_we       in   1   1=write, 0=read
//  a_bwen     in   BW  byte write enables; bit i enables byte i (ignored on reads)
//  a_addr     in   AW  word address
//  a_wdata    in   DW  write data
//  a_gnt      out  1   request accepted this cycle (combinational)
//  a_rvalid   out  1   read data valid; pulses 1 cycle after a granted read
//  a_rdata    out  DW  read data; 0 when a_rvalid=0
//  b_*        --   --  same set of ports as a_*, for requester B
//  ram_cen    out  1   RAM chip enable
//  ram_wen    out  1   RAM write enable
//  ram_bwen   out  BW  RAM byte enables
//  ram_addr   out  AW  RAM address
//  ram_din    out  DW  RAM write data
//  ram_dout   in   DW  RAM read data; valid the cycle after a read access
// BEHAVIOUR
//  Reset (sync): state=INIT (or RUN when INIT_EN=0), init_cnt=0, last=B, rvalid regs=0.
//   While reset=1: all outputs 0, ram_cen=0. init_done=0 until INIT completes.
//  INIT: each cycle ram_cen=1, ram_wen=1, ram_bwen=all 1s, ram_addr=init_cnt, ram_din=INIT_VALUE.
//   Takes DEPTH cycles (addr 0..DEPTH-1, no wrap). After the DEPTH-1 write: state=RUN, init_done=1
//   from the next cycle. No gnt during INIT; requests stay pending.
//  INIT_EN=0: init_done=1 from the first cycle after reset deasserts.
//  RUN arbitration (combinational, same cycle):
//   only A requests -> A wins; only B requests -> B wins;
//   both request -> winner is the port != last. last updates to the winner on every grant.
//   The first tie after reset goes to A.
//  Winner: x_gnt=1; ram_cen=1; ram_wen=x_we; ram_bwen=x_we ? x_bwen : 0; ram_addr=x_addr;
//   ram_din=x_wdata. No winner: ram_cen=0 and all other ram_* outputs = 0.
//  Reads: x_rvalid is registered: 1 in the cycle after a granted read, else 0.
//   x_rdata = x_rvalid ? ram_dout : 0. Latency is exactly 1; back-to-back reads give back-to-back
//   rvalid. A grant in cycle N and a grant to the other port in N+1 return both results in order.
//  Writes: complete on the gnt cycle; no response. Read-after-write to the same address in the
//   next cycle returns the new data (the RAM is written at that edge).
//  Each port is granted at most once per cycle. A starved port waits at most 1 grant.
//  Reset mid-operation: pending rvalid pulses are dropped, last=B, INIT restarts from address 0
//   and re-clears the whole memory.
// TESTING (DATA_WIDTH=32, DEPTH=16, INIT_EN=1, INIT_VALUE=0)
//  1 Release reset -> 16 cycles of ram writes, addr 0..15, din=0, bwen=4'hF; init_done=1 on the
//    17th cycle; a_req held during INIT -> a_gnt=0 until then.
//  2 A writes addr 3 = 0xDEADBEEF with bwen=4'hF, then reads addr 3 -> a_rvalid 1 cycle after the
//    read gnt, a_rdata=0xDEADBEEF; b_rvalid stays 0.
//  3 A writes addr 5, bwen=4'b0101, data 0x11223344 over 0 -> read returns 0x00220044.
//  4 a_req and b_req held high 6 cycles, reads -> grants alternate A,B,A,B,A,B; each rvalid lands
//    on the matching port with the data for that port's address.
//  5 A read granted at cycle N, reset asserted at N+1 -> a_rvalid stays 0, init_done falls, INIT
//    rewrites addr 0..15 and a later read of addr 3 returns 0.

Source files
------------

// File: rtl/ram_sp_arbiter.sv
// Round-robin arbiter sharing one single-port byte-masked RAM between requesters A and B,
// with an optional post-reset fill of every word with INIT_VALUE.
module ram_sp_arbiter #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 16,
    parameter int                    INIT_EN    = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    localparam int                   AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int                   BW         = DATA_WIDTH / 8
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  init_done,

    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [BW-1:0]         a_bwen,
    input  logic [AW-1:0]         a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,

    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [BW-1:0]         b_bwen,
    input  logic [AW-1:0]         b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,

    output logic                  ram_cen,
    output logic                  ram_wen,
    output logic [BW-1:0]         ram_bwen,
    output logic [AW-1:0]         ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    // Requester handshake: x_req is held with its command fields stable until x_gnt is seen
    // high in the same cycle; a granted read answers with a one-cycle x_rvalid pulse next cycle.

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic LAST_A = 1'b0;
    localparam logic LAST_B = 1'b1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_e          state_q, state_d;
    logic [AW-1:0]   init_cnt_q, init_cnt_d;
    logic            last_q, last_d;
    logic            a_rvalid_q, a_rvalid_d;
    logic            b_rvalid_q, b_rvalid_d;
    logic            a_win, b_win;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        last_d     = last_q;
        a_rvalid_d = 1'b0;
        b_rvalid_d = 1'b0;
        a_win      = 1'b0;
        b_win      = 1'b0;
        a_gnt      = 1'b0;
        b_gnt      = 1'b0;
        ram_cen    = 1'b0;
        ram_wen    = 1'b0;
        ram_bwen   = '0;
        ram_addr   = '0;
        ram_din    = '0;

        if (!reset) begin
            case (state_q)
                ST_INIT: begin
                    ram_cen  = 1'b1;
                    ram_wen  = 1'b1;
                    ram_bwen = '1;
                    ram_addr = init_cnt_q;
                    ram_din  = INIT_VALUE;
                    if (init_cnt_q == LAST_ADDR) begin
                        state_d    = ST_RUN;
                        init_cnt_d = '0;
                    end else begin
                        init_cnt_d = init_cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    // On a tie the port that did not win last time goes first.
                    a_win = a_req && (!b_req || (last_q == LAST_B));
                    b_win = b_req && !a_win;
                    if (a_win) begin
                        a_gnt      = 1'b1;
                        ram_cen    = 1'b1;
                        ram_wen    = a_we;
                        ram_bwen   = a_we ? a_bwen : '0;
                        ram_addr   = a_addr;
                        ram_din    = a_wdata;
                        a_rvalid_d = !a_we;
                        last_d     = LAST_A;
                    end else if (b_win) begin
                        b_gnt      = 1'b1;
                        ram_cen    = 1'b1;
                        ram_wen    = b_we;
                        ram_bwen   = b_we ? b_bwen : '0;
                        ram_addr   = b_addr;
                        ram_din    = b_wdata;
                        b_rvalid_d = !b_we;
                        last_d     = LAST_B;
                    end
                end
                default: state_d = ST_INIT;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
            init_cnt_q <= '0;
            last_q     <= LAST_B;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            last_q     <= last_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
        end
    end

    // Registered flags may still hold a pulse during the first reset cycle, so mask them.
    assign init_done = !reset && (state_q == ST_RUN);
    assign a_rvalid  = !reset && a_rvalid_q;
    assign b_rvalid  = !reset && b_rvalid_q;
    assign a_rdata   = a_rvalid ? ram_dout : '0;
    assign b_rdata   = b_rvalid ? ram_dout : '0;

endmodule
